// File: rtl/model_sb_pkg.sv
// Shared record layout and mismatch-code bit positions for the model-vs-DUT scoreboard.
package model_sb_pkg;

  localparam int RESULT_W = 3;
  localparam int ADDR_W   = 5;
  localparam int ERR_W    = 4;

  localparam int ERR_RESULT = 0;
  localparam int ERR_WEN    = 1;
  localparam int ERR_ADDR   = 2;
  localparam int ERR_DATA   = 3;

  // Record header; rd_data (XLEN wide) is appended below it as the low bits.
  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic                rd_wen;
    logic [ADDR_W-1:0]   rd_addr;
  } rec_hdr_t;

  localparam int HDR_W = $bits(rec_hdr_t);

endpackage

// File: rtl/model_sb_fifo.sv
// Synchronous FIFO of DEPTH records; a push to a full FIFO is dropped unless a pop frees a slot.
module model_sb_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 8
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge g_clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/model_scoreboard.sv
// In-order DUT/GRM writeback comparator with counters and sticky error flags.
// Optional feature: define MODEL_SB_HALT_EN to freeze comparison after the first mismatch.
module model_scoreboard
  import model_sb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                dut_in_valid,
  input  logic                dut_out_valid,
  input  logic [RESULT_W-1:0] dut_result,
  input  logic                dut_rd_wen,
  input  logic [ADDR_W-1:0]   dut_rd_addr,
  input  logic [XLEN-1:0]     dut_rd_data,
  input  logic                grm_out_valid,
  input  logic [RESULT_W-1:0] grm_result,
  input  logic                grm_rd_wen,
  input  logic [ADDR_W-1:0]   grm_rd_addr,
  input  logic [XLEN-1:0]     grm_rd_data,
  output logic                chk_valid,
  output logic                chk_err,
  output logic [ERR_W-1:0]    chk_err_code,
  output logic [CW-1:0]       match_count,
  output logic [CW-1:0]       err_count,
  output logic [CW-1:0]       outstanding,
  output logic                dut_ovf,
  output logic                grm_ovf,
  output logic                spurious,
  output logic                timeout,
  output logic                halted
);

  localparam int REC_W = HDR_W + XLEN;
  localparam int IW    = $clog2(TIMEOUT + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [REC_W-1:0] dut_rec, grm_rec, dut_head, grm_head;
  logic             dut_full, dut_empty, grm_full, grm_empty;
  rec_hdr_t         dut_hdr, grm_hdr;
  logic             compare;
  logic [ERR_W-1:0] code;

  logic             chk_valid_q, chk_valid_d;
  logic [ERR_W-1:0] chk_code_q, chk_code_d;
  logic [CW-1:0]    match_q, match_d, err_q, err_d, outst_q, outst_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             dovf_q, dovf_d, govf_q, govf_d, spur_q, spur_d;
  logic             tmo_q, tmo_d, halted_q, halted_d;

  assign dut_rec = {dut_result, dut_rd_wen, dut_rd_addr, dut_rd_data};
  assign grm_rec = {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data};

  model_sb_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_dut_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push_i   (dut_out_valid),
    .wdata_i  (dut_rec),
    .pop_i    (compare),
    .rdata_o  (dut_head),
    .full_o   (dut_full),
    .empty_o  (dut_empty)
  );

  model_sb_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_grm_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push_i   (grm_out_valid),
    .wdata_i  (grm_rec),
    .pop_i    (compare),
    .rdata_o  (grm_head),
    .full_o   (grm_full),
    .empty_o  (grm_empty)
  );

  assign dut_hdr = dut_head[REC_W-1 -: HDR_W];
  assign grm_hdr = grm_head[REC_W-1 -: HDR_W];
  assign compare = !dut_empty && !grm_empty && !halted_q;

  // Address/data only matter when the reference actually writes a register.
  always_comb begin
    code             = '0;
    code[ERR_RESULT] = (dut_hdr.result != grm_hdr.result);
    code[ERR_WEN]    = (dut_hdr.rd_wen != grm_hdr.rd_wen);
    if (grm_hdr.rd_wen) begin
      code[ERR_ADDR] = (dut_hdr.rd_addr != grm_hdr.rd_addr);
      code[ERR_DATA] = (dut_head[XLEN-1:0] != grm_head[XLEN-1:0]);
    end
  end

  always_comb begin
    chk_valid_d = compare;
    chk_code_d  = compare ? code : '0;
    match_d     = match_q;
    err_d       = err_q;
    if (compare) begin
      if (|code) err_d   = sat_inc(err_q);
      else       match_d = sat_inc(match_q);
    end

    outst_d = outst_q;
    spur_d  = spur_q | (dut_out_valid && (outst_q == '0));
    if (dut_in_valid && !dut_out_valid)
      outst_d = sat_inc(outst_q);
    else if (!dut_in_valid && dut_out_valid && (outst_q != '0))
      outst_d = outst_q - 1'b1;

    idle_d = idle_q;
    if (dut_out_valid || (outst_q == '0)) idle_d = '0;
    else if (idle_q != IW'(TIMEOUT))      idle_d = idle_q + 1'b1;
    tmo_d = tmo_q | (idle_d == IW'(TIMEOUT));

    dovf_d = dovf_q | (dut_out_valid && dut_full && !compare);
    govf_d = govf_q | (grm_out_valid && grm_full && !compare);

`ifdef MODEL_SB_HALT_EN
    halted_d = halted_q | (compare && (|code));
`else
    halted_d = 1'b0;
`endif
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      chk_valid_q <= 1'b0;
      chk_code_q  <= '0;
      match_q     <= '0;
      err_q       <= '0;
      outst_q     <= '0;
      idle_q      <= '0;
      dovf_q      <= 1'b0;
      govf_q      <= 1'b0;
      spur_q      <= 1'b0;
      tmo_q       <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      chk_valid_q <= chk_valid_d;
      chk_code_q  <= chk_code_d;
      match_q     <= match_d;
      err_q       <= err_d;
      outst_q     <= outst_d;
      idle_q      <= idle_d;
      dovf_q      <= dovf_d;
      govf_q      <= govf_d;
      spur_q      <= spur_d;
      tmo_q       <= tmo_d;
      halted_q    <= halted_d;
    end
  end

  assign chk_valid    = chk_valid_q;
  assign chk_err_code = chk_code_q;
  assign chk_err      = |chk_code_q;
  assign match_count  = match_q;
  assign err_count    = err_q;
  assign outstanding  = outst_q;
  assign dut_ovf      = dovf_q;
  assign grm_ovf      = govf_q;
  assign spurious     = spur_q;
  assign timeout      = tmo_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_model_scoreboard.sv
// Bench for model_scoreboard: directed scenarios plus a random run against a queue-based reference model.
module tb_model_scoreboard;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 8;
  localparam int CW      = 16;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = 65535;

  typedef struct packed {
    logic [2:0]  res;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } rec_t;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        dut_in_valid = 1'b0, dut_out_valid = 1'b0, dut_rd_wen = 1'b0;
  logic [2:0]  dut_result = '0;
  logic [4:0]  dut_rd_addr = '0;
  logic [31:0] dut_rd_data = '0;
  logic        grm_out_valid = 1'b0, grm_rd_wen = 1'b0;
  logic [2:0]  grm_result = '0;
  logic [4:0]  grm_rd_addr = '0;
  logic [31:0] grm_rd_data = '0;

  logic          chk_valid, chk_err;
  logic [3:0]    chk_err_code;
  logic [CW-1:0] match_count, err_count, outstanding;
  logic          dut_ovf, grm_ovf, spurious, timeout, halted;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  rec_t       mq_d[$], mq_g[$];
  logic       m_valid;
  logic [3:0] m_code;
  int         m_match, m_err, m_out, m_idle;
  logic       m_dovf, m_govf, m_spur, m_tmo, m_halt;

  model_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .dut_in_valid  (dut_in_valid),
    .dut_out_valid (dut_out_valid),
    .dut_result    (dut_result),
    .dut_rd_wen    (dut_rd_wen),
    .dut_rd_addr   (dut_rd_addr),
    .dut_rd_data   (dut_rd_data),
    .grm_out_valid (grm_out_valid),
    .grm_result    (grm_result),
    .grm_rd_wen    (grm_rd_wen),
    .grm_rd_addr   (grm_rd_addr),
    .grm_rd_data   (grm_rd_data),
    .chk_valid     (chk_valid),
    .chk_err       (chk_err),
    .chk_err_code  (chk_err_code),
    .match_count   (match_count),
    .err_count     (err_count),
    .outstanding   (outstanding),
    .dut_ovf       (dut_ovf),
    .grm_ovf       (grm_ovf),
    .spurious      (spurious),
    .timeout       (timeout),
    .halted        (halted)
  );

  always #5 g_clk = ~g_clk;

  task automatic set_dut(input rec_t r);
    dut_out_valid = 1'b1;
    dut_result = r.res; dut_rd_wen = r.wen; dut_rd_addr = r.addr; dut_rd_data = r.data;
  endtask

  task automatic set_grm(input rec_t r);
    grm_out_valid = 1'b1;
    grm_result = r.res; grm_rd_wen = r.wen; grm_rd_addr = r.addr; grm_rd_data = r.data;
  endtask

  task automatic clear_in();
    dut_in_valid = 1'b0; dut_out_valid = 1'b0; grm_out_valid = 1'b0;
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.res  = 3'($urandom_range(0, 7));
    r.wen  = 1'($urandom_range(0, 1));
    r.addr = 5'($urandom_range(0, 31));
    r.data = $urandom;
    return r;
  endfunction

  // Advance the model by the current inputs, then let the DUT take the same edge.
  task automatic cyc();
    rec_t d, g, din, gin;
    din = '{dut_result, dut_rd_wen, dut_rd_addr, dut_rd_data};
    gin = '{grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data};
    if (!g_resetn) begin
      mq_d.delete(); mq_g.delete();
      m_valid = 0; m_code = 0; m_match = 0; m_err = 0; m_out = 0; m_idle = 0;
      m_dovf = 0; m_govf = 0; m_spur = 0; m_tmo = 0; m_halt = 0;
    end else begin
      m_valid = 0; m_code = 0;
      if (mq_d.size() > 0 && mq_g.size() > 0 && !m_halt) begin
        d = mq_d.pop_front();
        g = mq_g.pop_front();
        m_valid   = 1;
        m_code[0] = (d.res != g.res);
        m_code[1] = (d.wen != g.wen);
        m_code[2] = g.wen && (d.addr != g.addr);
        m_code[3] = g.wen && (d.data != g.data);
        if (m_code != 0) begin
          if (m_err < CMAX) m_err++;
`ifdef MODEL_SB_HALT_EN
          m_halt = 1;
`endif
        end else if (m_match < CMAX) m_match++;
      end
      if (dut_out_valid) begin
        if (mq_d.size() < DEPTH) mq_d.push_back(din); else m_dovf = 1;
      end
      if (grm_out_valid) begin
        if (mq_g.size() < DEPTH) mq_g.push_back(gin); else m_govf = 1;
      end
      if (dut_out_valid && m_out == 0) m_spur = 1;
      if (dut_out_valid || m_out == 0) m_idle = 0;
      else if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT) m_tmo = 1;
      if (dut_in_valid && !dut_out_valid && m_out < CMAX) m_out++;
      else if (!dut_in_valid && dut_out_valid && m_out > 0) m_out--;
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    g_resetn = 1'b0;
    cyc();
    cyc();
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({chk_valid, chk_err, chk_err_code} !== 6'b0) begin
      n_bad++; $display("FAIL reset_chk: got %b want 000000", {chk_valid, chk_err, chk_err_code});
    end
    n_cmp++;
    if (match_count !== '0 || err_count !== '0) begin
      n_bad++; $display("FAIL reset_counts: got match=%0d err=%0d want 0/0", match_count, err_count);
    end
    n_cmp++;
    if (outstanding !== '0) begin
      n_bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    n_cmp++;
    if ({dut_ovf, grm_ovf, spurious, timeout, halted} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {dut_ovf, grm_ovf, spurious, timeout, halted});
    end
  endtask

  task automatic test_same_cycle();
    rec_t r;
    do_reset();
    dut_in_valid = 1'b1;
    cyc();
    clear_in();
    r = '{3'd0, 1'b1, 5'd5, 32'hDEADBEEF};
    set_dut(r);
    set_grm(r);
    cyc();
    clear_in();
    n_cmp++;
    if (chk_valid !== 1'b0) begin
      n_bad++; $display("FAIL same_n1_valid: got %b want 0", chk_valid);
    end
    cyc();
    n_cmp++;
    if ({chk_valid, chk_err} !== 2'b10) begin
      n_bad++; $display("FAIL same_n2_chk: got valid=%b err=%b want 1/0", chk_valid, chk_err);
    end
    n_cmp++;
    if (match_count !== 16'd1) begin
      n_bad++; $display("FAIL same_match_count: got %0d want 1", match_count);
    end
    cyc();
    n_cmp++;
    if (chk_valid !== 1'b0) begin
      n_bad++; $display("FAIL same_pulse: got %b want 0", chk_valid);
    end
  endtask

  task automatic test_in_order();
    rec_t recs[3];
    int seen, errs;
    do_reset();
    foreach (recs[i]) recs[i] = rand_rec();
    seen = 0; errs = 0;
    for (int t = 0; t < 17; t++) begin
      clear_in();
      if (t < 3) begin set_grm(recs[t]); dut_in_valid = 1'b1; end
      if (t >= 10 && t < 13) set_dut(recs[t-10]);
      cyc();
      if (chk_valid === 1'b1) seen++;
      if (chk_err !== 1'b0) errs++;
    end
    clear_in();
    n_cmp++;
    if (seen != 3 || errs != 0) begin
      n_bad++; $display("FAIL in_order_pulses: got valid=%0d err=%0d want 3/0", seen, errs);
    end
    n_cmp++;
    if (match_count !== 16'd3 || err_count !== 16'd0) begin
      n_bad++; $display("FAIL in_order_counts: got match=%0d err=%0d want 3/0", match_count, err_count);
    end
  endtask

  task automatic pair(input rec_t g, input rec_t d);
    set_grm(g);
    set_dut(d);
    dut_in_valid = 1'b1;
    cyc();
    clear_in();
    cyc();
  endtask

  task automatic test_field_err();
    do_reset();
    pair('{3'd0, 1'b1, 5'd5, 32'h1}, '{3'd0, 1'b1, 5'd6, 32'h2});
    n_cmp++;
    if ({chk_valid, chk_err, chk_err_code} !== 6'b11_1100) begin
      n_bad++; $display("FAIL field_addr_data: got %b want 111100", {chk_valid, chk_err, chk_err_code});
    end
    n_cmp++;
    if (err_count !== 16'd1 || match_count !== 16'd0) begin
      n_bad++; $display("FAIL field_err_count: got err=%0d match=%0d want 1/0", err_count, match_count);
    end
`ifndef MODEL_SB_HALT_EN
    pair('{3'd0, 1'b0, 5'd5, 32'h1}, '{3'd0, 1'b0, 5'd9, 32'h7});
    n_cmp++;
    if ({chk_valid, chk_err, chk_err_code} !== 6'b10_0000 || match_count !== 16'd1) begin
      n_bad++; $display("FAIL field_wen0: got %b match=%0d want 100000 match=1", {chk_valid, chk_err, chk_err_code}, match_count);
    end
    pair('{3'd3, 1'b1, 5'd5, 32'h1}, '{3'd2, 1'b1, 5'd5, 32'h1});
    n_cmp++;
    if ({chk_valid, chk_err, chk_err_code} !== 6'b11_0001) begin
      n_bad++; $display("FAIL field_result: got %b want 110001", {chk_valid, chk_err, chk_err_code});
    end
    pair('{3'd0, 1'b0, 5'd5, 32'h1}, '{3'd0, 1'b1, 5'd4, 32'h9});
    n_cmp++;
    if ({chk_valid, chk_err, chk_err_code} !== 6'b11_0010 || err_count !== 16'd3) begin
      n_bad++; $display("FAIL field_wen: got %b err=%0d want 110010 err=3", {chk_valid, chk_err, chk_err_code}, err_count);
    end
`endif
  endtask

  task automatic test_overflow();
    rec_t r;
    int seen, errs;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      dut_in_valid = 1'b1;
      cyc();
    end
    clear_in();
    for (int i = 0; i < 9; i++) begin
      r = '{3'd1, 1'b1, 5'(i), 32'(i)};
      set_dut(r);
      cyc();
    end
    clear_in();
    n_cmp++;
    if ({dut_ovf, grm_ovf} !== 2'b10) begin
      n_bad++; $display("FAIL ovf_flags: got dut=%b grm=%b want 1/0", dut_ovf, grm_ovf);
    end
    seen = 0; errs = 0;
    for (int t = 0; t < 13; t++) begin
      clear_in();
      if (t < 9) begin
        r = '{3'd1, 1'b1, 5'(t), 32'(t)};
        set_grm(r);
      end
      cyc();
      if (chk_valid === 1'b1) seen++;
      if (chk_err !== 1'b0) errs++;
    end
    clear_in();
    n_cmp++;
    if (seen != 8 || errs != 0 || match_count !== 16'd8) begin
      n_bad++; $display("FAIL ovf_drain: got valid=%0d err=%0d match=%0d want 8/0/8", seen, errs, match_count);
    end
  endtask

  task automatic test_timeout_spurious();
    do_reset();
    dut_in_valid = 1'b1;
    cyc();
    clear_in();
    repeat (3) cyc();
    n_cmp++;
    if (timeout !== 1'b0 || outstanding !== 16'd1) begin
      n_bad++; $display("FAIL timeout_early: got tmo=%b out=%0d want 0/1", timeout, outstanding);
    end
    cyc();
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_set: got %b want 1", timeout);
    end
    do_reset();
    set_dut('{3'd0, 1'b0, 5'd0, 32'h0});
    cyc();
    clear_in();
    n_cmp++;
    if (spurious !== 1'b1 || outstanding !== 16'd0) begin
      n_bad++; $display("FAIL spurious: got sp=%b out=%0d want 1/0", spurious, outstanding);
    end
  endtask

  task automatic test_reset_midway();
    int seen;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_dut(rand_rec());
      cyc();
    end
    clear_in();
    g_resetn = 1'b0;
    cyc();
    g_resetn = 1'b1;
    n_cmp++;
    if (match_count !== '0 || err_count !== '0 || outstanding !== '0 || spurious !== 1'b0) begin
      n_bad++; $display("FAIL midreset_counts: got m=%0d e=%0d o=%0d sp=%b want 0", match_count, err_count, outstanding, spurious);
    end
    seen = 0;
    for (int t = 0; t < 7; t++) begin
      clear_in();
      if (t < 3) set_grm(rand_rec());
      cyc();
      if (chk_valid !== 1'b0) seen++;
    end
    clear_in();
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL midreset_nochk: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    logic [11:0] seen;
    do_reset();
    seen = '0;
    for (int t = 0; t < 12; t++) begin
      clear_in();
      if (t < 10) begin
        r = rand_rec();
        set_dut(r);
        set_grm(r);
        dut_in_valid = 1'b1;
      end
      cyc();
      seen[t] = chk_valid;
    end
    clear_in();
    n_cmp++;
    if (seen !== 12'b0111_1111_1110 || match_count !== 16'd10) begin
      n_bad++; $display("FAIL b2b: got pattern=%b match=%0d want 011111111110 match=10", seen, match_count);
    end
  endtask

`ifdef MODEL_SB_HALT_EN
  task automatic test_halt();
    rec_t r;
    int seen;
    do_reset();
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      clear_in();
      if (t < 4) begin
        r = rand_rec();
        set_grm(r);
        if (t == 0) r.res = r.res ^ 3'd1;
        set_dut(r);
        dut_in_valid = 1'b1;
      end
      cyc();
      if (chk_valid === 1'b1) seen++;
    end
    clear_in();
    n_cmp++;
    if (halted !== 1'b1 || match_count !== 16'd0 || err_count !== 16'd1 || seen != 1) begin
      n_bad++; $display("FAIL halt: got h=%b m=%0d e=%0d pulses=%0d want 1/0/1/1", halted, match_count, err_count, seen);
    end
  endtask
`endif

  task automatic test_random();
    rec_t recs[60];
    rec_t r;
    int gi, di;
    do_reset();
    foreach (recs[i]) begin
      recs[i] = rand_rec();
      if ($urandom_range(0, 3) == 0) recs[i].wen = 1'b0;
    end
    gi = 0; di = 0;
    for (int t = 0; t < 400; t++) begin
      clear_in();
      dut_in_valid = 1'($urandom_range(0, 1));
      if (gi < 60 && $urandom_range(0, 1) == 1) begin
        set_grm(recs[gi]); gi++;
      end
      if (di < 60 && $urandom_range(0, 2) != 0) begin
        r = recs[di];
        if ($urandom_range(0, 15) == 0) r.data[$urandom_range(0, 31)] ^= 1'b1;
        if ($urandom_range(0, 31) == 0) r.addr ^= 5'd1;
        set_dut(r); di++;
      end
      if (t == 200) g_resetn = 1'b0;
      if (t == 201) g_resetn = 1'b1;
      cyc();
      n_cmp++;
      if ({chk_valid, chk_err, chk_err_code} !== {m_valid, |m_code, m_code}) begin
        n_bad++; $display("FAIL rand_chk t=%0d: got %b want %b", t, {chk_valid, chk_err, chk_err_code}, {m_valid, |m_code, m_code});
      end
      n_cmp++;
      if (match_count !== CW'(m_match) || err_count !== CW'(m_err) || outstanding !== CW'(m_out)) begin
        n_bad++; $display("FAIL rand_counts t=%0d: got m=%0d e=%0d o=%0d want %0d/%0d/%0d", t, match_count, err_count, outstanding, m_match, m_err, m_out);
      end
      n_cmp++;
      if ({dut_ovf, grm_ovf, spurious, timeout, halted} !== {m_dovf, m_govf, m_spur, m_tmo, m_halt}) begin
        n_bad++; $display("FAIL rand_flags t=%0d: got %b want %b", t, {dut_ovf, grm_ovf, spurious, timeout, halted}, {m_dovf, m_govf, m_spur, m_tmo, m_halt});
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_in_order();
    test_field_err();
    test_overflow();
    test_timeout_spurious();
    test_reset_midway();
    test_back_to_back();
`ifdef MODEL_SB_HALT_EN
    test_halt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
